hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core (F, D, EX, MEM, WB). It keeps a shadow scoreboard of the instructions in EX, MEM and WB. From that it drives the execute stage's operand-bypass selects (`rs1s`/`rs2s`) and its `flush` input, and the fetch/decode stall and flush controls. It sequences load-use bubbles, branch/jump redirects (from execute's `pc_reset`) and the end-of-program halt.

---
 rtl/hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller: bypass selects, load-use stall, redirect flush, halt.
// Optional build macro HAZARD_STATS_EN adds the stall_cnt/flush_cnt performance counters.
package hazard_pkg;
  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_MEM = 2'd1,
    SRC_WB  = 2'd2
  } hu_src_e;
endpackage

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_is_final,
  input  logic             pc_reset,
  output hu_src_e          rs1s,
  output hu_src_e          rs2s,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic             bubble_ex,
  output logic             halt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             reg_write;
    logic             mem_read;
    logic             is_final;
  } slot_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_LU_STALL,
    S_REDIRECT,
    S_HALT
  } state_e;

  state_e state;
  slot_t  id_slot;
  slot_t  ex_q;
  slot_t  mem_q;
  slot_t  wb_q;
  logic   lu;
  logic   final_wb;

  // Source registers of retiring instructions are kept for completeness only.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.rs1, wb_q.rs2, wb_q.mem_read};

  function automatic logic writes_reg(input slot_t s, input logic [REG_W-1:0] src);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == src);
  endfunction

  function automatic hu_src_e fwd_sel(input logic ex_valid, input logic [REG_W-1:0] src,
                                      input slot_t m, input slot_t w);
    if (!ex_valid)              return SRC_REG;
    else if (writes_reg(m, src)) return SRC_MEM;
    else if (writes_reg(w, src)) return SRC_WB;
    else                         return SRC_REG;
  endfunction

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.rd        = id_rd;
    id_slot.rs1       = id_rs1;
    id_slot.rs2       = id_rs2;
    id_slot.reg_write = id_reg_write;
    id_slot.mem_read  = id_mem_read;
    id_slot.is_final  = id_is_final;
  end

  assign rs1s = fwd_sel(ex_q.valid, ex_q.rs1, mem_q, wb_q);
  assign rs2s = fwd_sel(ex_q.valid, ex_q.rs2, mem_q, wb_q);

  assign lu = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
              ((id_rs1 == ex_q.rd) || (id_rs2 == ex_q.rd));

  assign final_wb = wb_q.valid && wb_q.is_final;

  // A redirect outranks a load-use stall: the dependent instruction is wrong-path anyway.
  always_comb begin
    stall_fd = 1'b0;
    flush_fd = 1'b0;
    unique case (state)
      S_RUN: begin
        flush_fd = pc_reset;
        stall_fd = lu && !pc_reset;
      end
      S_HALT:  stall_fd = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      mem_q.valid <= ex_q.valid && !bubble_ex;
      ex_q        <= id_slot;
      ex_q.valid  <= id_valid && !stall_fd && !flush_fd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      bubble_ex <= 1'b0;
      halt      <= 1'b0;
    end else if (final_wb) begin
      state     <= S_HALT;
      bubble_ex <= 1'b1;
      halt      <= 1'b1;
    end else begin
      unique case (state)
        S_RUN: begin
          if (pc_reset) begin
            state     <= S_REDIRECT;
            bubble_ex <= 1'b1;
          end else if (lu) begin
            state     <= S_LU_STALL;
            bubble_ex <= 1'b1;
          end else begin
            bubble_ex <= 1'b0;
          end
        end
        S_LU_STALL, S_REDIRECT: begin
          state     <= S_RUN;
          bubble_ex <= 1'b0;
        end
        S_HALT: begin
          bubble_ex <= 1'b1;
          halt      <= 1'b1;
        end
        default: begin
          state     <= S_RUN;
          bubble_ex <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_fd && (state != S_HALT)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_fd)                      flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl; build with +define+HAZARD_STATS_EN to cover the counters.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int SIG_RS1 = 0, SIG_RS2 = 1, SIG_STALL = 2, SIG_FLUSH = 3,
                 SIG_BUBBLE = 4, SIG_HALT = 5, SIG_SCNT = 6, SIG_FCNT = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, id_is_final;
  logic       pc_reset;
  hu_src_e    rs1s, rs2s;
  logic       stall_fd, flush_fd, bubble_ex, halt;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_is_final(id_is_final), .pc_reset(pc_reset), .rs1s(rs1s), .rs2s(rs2s),
    .stall_fd(stall_fd), .flush_fd(flush_fd), .bubble_ex(bubble_ex), .halt(halt)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] read_sig(input int s);
    case (s)
      SIG_RS1:    return 32'(rs1s);
      SIG_RS2:    return 32'(rs2s);
      SIG_STALL:  return 32'(stall_fd);
      SIG_FLUSH:  return 32'(flush_fd);
      SIG_BUBBLE: return 32'(bubble_ex);
      SIG_HALT:   return 32'(halt);
`ifdef HAZARD_STATS_EN
      SIG_SCNT:   return stall_cnt;
      SIG_FCNT:   return flush_cnt;
`endif
      default:    return 32'hdead_beef;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check_eq(sb[i].tag, read_sig(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int k, input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.at = cyc + k; e.tag = tag; e.sig = sig; e.val = val;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fin);
    id_valid = 1'b1; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; id_is_final = fin;
  endtask

  task automatic idle_id();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_is_final = 1'b0;
  endtask

  task automatic drain();
    idle_id();
    repeat (4) step();
  endtask

  task automatic load_use(input string tag);
    issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    step();
    issue(5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_at(0, {tag, "_stall"},   SIG_STALL,  1);
    expect_at(0, {tag, "_flush"},   SIG_FLUSH,  0);
    expect_at(0, {tag, "_bub0"},    SIG_BUBBLE, 0);
    expect_at(1, {tag, "_bub1"},    SIG_BUBBLE, 1);
    expect_at(1, {tag, "_unstall"}, SIG_STALL,  0);
    expect_at(2, {tag, "_rs1"},     SIG_RS1,    32'(SRC_WB));
    expect_at(2, {tag, "_rs2"},     SIG_RS2,    32'(SRC_REG));
    expect_at(2, {tag, "_bub2"},    SIG_BUBBLE, 0);
    step();
    step();
    idle_id();
    step();
    drain();
  endtask

  initial begin
    int c0;
    rst = 1'b1; pc_reset = 1'b0;
    idle_id();
    step();
    step();
    expect_at(0, "rst_rs1",    SIG_RS1,    32'(SRC_REG));
    expect_at(0, "rst_rs2",    SIG_RS2,    32'(SRC_REG));
    expect_at(0, "rst_stall",  SIG_STALL,  0);
    expect_at(0, "rst_flush",  SIG_FLUSH,  0);
    expect_at(0, "rst_bubble", SIG_BUBBLE, 0);
    expect_at(0, "rst_halt",   SIG_HALT,   0);
`ifdef HAZARD_STATS_EN
    expect_at(0, "rst_scnt",   SIG_SCNT,   0);
    expect_at(0, "rst_fcnt",   SIG_FCNT,   0);
`endif
    step();
    rst = 1'b0;
    step();

    // add x5 ; sub x6,x5,x5
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); step();
    issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    expect_at(1, "b2b_rs1", SIG_RS1, 32'(SRC_MEM));
    expect_at(1, "b2b_rs2", SIG_RS2, 32'(SRC_MEM));
    expect_at(1, "b2b_stall", SIG_STALL, 0);
    step(); drain();

    // add x5 ; unrelated ; sub x6,x5,x5
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); step();
    issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0); step();
    issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    expect_at(1, "gap_rs1", SIG_RS1, 32'(SRC_WB));
    expect_at(1, "gap_rs2", SIG_RS2, 32'(SRC_WB));
    step(); drain();

    // two writers of x7, reader of x7
    issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0); step();
    issue(5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0); step();
    issue(5'd7, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_at(1, "dbl_rs1", SIG_RS1, 32'(SRC_MEM));
    expect_at(1, "dbl_rs2", SIG_RS2, 32'(SRC_REG));
    step(); drain();

    // x0 writer never forwards
    issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); step();
    issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_at(1, "x0_rs1", SIG_RS1, 32'(SRC_REG));
    expect_at(1, "x0_rs2", SIG_RS2, 32'(SRC_REG));
    step(); drain();

    // writer without reg_write never forwards
    issue(5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 1'b0); step();
    issue(5'd8, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_at(1, "norw_rs1", SIG_RS1, 32'(SRC_REG));
    step(); drain();

    // invalid EX slot yields REG even with a matching writer in MEM
    issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0); step();
    idle_id();
    expect_at(1, "inv_rs1", SIG_RS1, 32'(SRC_REG));
    step(); drain();

    // reset in the middle of a load-use stall
    issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0); step();
    issue(5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    expect_at(0, "mrst_stall", SIG_STALL, 1);
    expect_at(1, "mrst_bubble", SIG_BUBBLE, 0);
    expect_at(1, "mrst_stall1", SIG_STALL, 0);
    step();
    rst = 1'b0;
    step(); drain();

    load_use("lu1");
    load_use("lu2");
    load_use("lu3");

    // redirect with concurrent load-use; pc_reset held into the bubble is ignored
    issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0); step();
    issue(5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    pc_reset = 1'b1;
    expect_at(0, "rd1_flush", SIG_FLUSH, 1);
    expect_at(0, "rd1_stall", SIG_STALL, 0);
    expect_at(0, "rd1_bub0", SIG_BUBBLE, 0);
    expect_at(1, "rd1_bub1", SIG_BUBBLE, 1);
    expect_at(1, "rd1_noflush", SIG_FLUSH, 0);
    expect_at(2, "rd1_bub2", SIG_BUBBLE, 0);
    expect_at(2, "rd1_flush2", SIG_FLUSH, 0);
    step();
    idle_id();
    step();
    pc_reset = 1'b0;
    step(); drain();

    pc_reset = 1'b1;
    expect_at(0, "rd2_flush", SIG_FLUSH, 1);
    expect_at(1, "rd2_bub1", SIG_BUBBLE, 1);
    step();
    pc_reset = 1'b0;
    step(); drain();

`ifdef HAZARD_STATS_EN
    expect_at(0, "cnt_stall", SIG_SCNT, 3);
    expect_at(0, "cnt_flush", SIG_FCNT, 2);
`endif
    step();

    // final instruction: reaches WB at c0+3, halt from c0+4 for at least 20 cycles
    c0 = cyc;
    issue(5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1);
    expect_at(3, "fin_halt_pre", SIG_HALT, 0);
    for (int k = 4; k < 24; k++) expect_at(k, $sformatf("fin_halt%0d", k), SIG_HALT, 1);
    expect_at(4, "fin_stall", SIG_STALL, 1);
    expect_at(4, "fin_bubble", SIG_BUBBLE, 1);
    expect_at(4, "fin_flush", SIG_FLUSH, 0);
`ifdef HAZARD_STATS_EN
    expect_at(10, "fin_scnt", SIG_SCNT, 3);
    expect_at(10, "fin_fcnt", SIG_FCNT, 2);
`endif
    step();
    idle_id();
    while (cyc < c0 + 4) step();
    pc_reset = 1'b1;
    step();
    pc_reset = 1'b0;
    while (cyc < c0 + 24) step();
    rst = 1'b1;
    expect_at(1, "hrst_halt", SIG_HALT, 0);
    expect_at(1, "hrst_bubble", SIG_BUBBLE, 0);
    expect_at(1, "hrst_stall", SIG_STALL, 0);
    expect_at(1, "hrst_flush", SIG_FLUSH, 0);
`ifdef HAZARD_STATS_EN
    expect_at(1, "hrst_scnt", SIG_SCNT, 0);
`endif
    step();
    rst = 1'b0;
    step();
    step();

    check_eq("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
